sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Sequences the CHIP-8 DXYN draw operation on behalf of the cpu.
- Fetches sprite bytes from ram starting at the I register address and read-modify-write XORs them into the 128x64, 2-bit-per-pixel vram.
- Reports collision to the cpu.
- Sits between the cpu's decode stage and the ram/vram ports. The cpu muxes these ports to the blitter while busy is high.

Parameters:
- ADDR_W, 12, ram address width.
- VRAM_W, 128, vram width in cells (hires screen width).
- VRAM_H, 64, vram height in cells (hires screen height).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to draw; ignored while busy
- hires  in  1  1 = 128x64 addressing; 0 = 64x32 addressing, each pixel drawn as a 2x2 cell block
- x  in  7  sprite X (VX value, low 7 bits)
- y  in  6  sprite Y (VY value, low 6 bits)
- n  in  4  sprite height; 0 = 16x16 sprite (2 bytes/row)
- plane_mask  in  2  planes to draw (bit0 = plane 0, bit1 = plane 1)
- i_addr  in  ADDR_W  sprite base address
- ram_addr  out  ADDR_W  ram read address
- ram_dout  in  8  ram data, valid 1 cycle after ram_addr
- vram_hpos  out  7  vram column
- vram_vpos  out  6  vram row
- vram_pixelo  in  2  vram read data, valid 1 cycle after address
- vram_pixeli  out  2  vram write data
- vram_we  out  1  vram write strobe
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- collision  out  1  VF result; valid at done, held until the next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE.
- IDLE:
  - start=1 latches x, y, n, plane_mask, hires and i_addr; clears collision; sets busy.
  - Next state is PLANE.
- PLANE:
  - Selects the lowest remaining set plane bit.
  - If none remain, go to DONE.
  - plane_mask=0 gives DONE after 2 cycles with no ram or vram access.
- Geometry:
  - rows = (n==0) ? 16 : n.
  - bytes/row = (n==0) ? 2 : 1.
  - Sprite data is sequential from i_addr. Plane 1 data follows plane 0 data when both planes are set (offset = rows*bytes/row).
  - ram_addr wraps modulo 2^ADDR_W.
- FETCH then LATCH:
  - FETCH drives ram_addr; LATCH captures ram_dout into the shift register one cycle later.
  - Each bit is processed MSB first. Zero bits are skipped at 1 cycle each with no vram access.
- Set bit:
  - Screen coordinate: px = (x mod W) + col, py = (y mod H) + row, where W,H = 128,64 (hires) or 64,32 (lores). The start position always wraps.
  - Pixel beyond the right or bottom edge: clipped (skipped).
  - Cells visited: hires visits (px,py). Lores visits (2px,2py), (2px+1,2py), (2px,2py+1), (2px+1,2py+1), in that order.
- Per cell read-modify-write (2 cycles):
  - RD cycle drives the address.
  - WR cycle drives vram_we=1 with vram_pixeli = vram_pixelo XOR plane bit; the other plane bit is preserved.
  - If the plane bit was 1 before the XOR, set collision.
  - The address is held stable across RD and WR.
- Row and plane sequencing: after the last bit of the last byte of a row, advance the row; after the last row, return to PLANE.
- DONE:
  - done=1 for one cycle; busy falls in the same cycle; return to IDLE.
  - busy and done are never high in the same cycle as an accepted start.
- start while busy is ignored (no queueing).
- Reset mid-draw aborts immediately. A vram write already performed stays in vram; no done pulse is issued.
- vram_we is never asserted outside the WR cycle. ram and vram addresses hold their last value when idle.

Optional Feature:
- Macro: SPRITE_BLITTER_WRAP_EN.
- Defined: pixels beyond the right or bottom edge wrap modulo W/H instead of being clipped (XO-CHIP wrap quirk). Collision applies normally to wrapped pixels.
- Undefined: clipping exactly as in Behaviour.

Decomposition:
- Shared package (chip8_pkg):
  - state enum: IDLE, PLANE, FETCH, LATCH, BIT, RD, WR, DONE
  - screen constants: LORES_W=64, LORES_H=32, HIRES_W=128, HIRES_H=64
  - BIG_SPRITE_ROWS=16
- Sub-module blit_coord (combinational): maps (hires, x, y, row, col, sub-cell index) to vram hpos/vpos plus a clip flag. Keeps the lores/hires and wrap logic out of the FSM.

Test Plan:
- Hires, x=0, y=0, n=1, mask=01, ram[0x200]=0x80, vram clear -> one RD/WR at (0,0); pixeli=01; collision=0; done after fixed cycle count; all other cells untouched.
- Repeat the same draw -> (0,0) returns to 00; collision=1.
- Lores, x=63, y=31, n=1, byte 0xC0 -> px=63 writes cells (126..127, 62..63). Second bit clipped (no vram_we). With SPRITE_BLITTER_WRAP_EN, cells (0..1, 62..63) are written.
- Hires, n=0, mask=11, i_addr=0x300 -> reads 0x300..0x31F for plane 0 and 0x320..0x33F for plane 1. 16x16 pattern lands in both bits; each pixel's other plane bit is preserved.
- x=130 (mod 128 = 2), y=70 (mod 64 = 6) hires -> the draw starts at (2,6).
- start pulsed while busy -> ignored. Reset mid-draw -> outputs return to 0, busy=0, no done; the next start draws correctly.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared state encoding and screen geometry for the CHIP-8 sprite blitter.
package chip8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLANE,
        FETCH,
        LATCH,
        BIT,
        RD,
        WR,
        DONE
    } state_t;

    localparam int LORES_W         = 64;
    localparam int LORES_H         = 32;
    localparam int HIRES_W         = 128;
    localparam int HIRES_H         = 64;
    localparam int BIG_SPRITE_ROWS = 16;

endpackage

// File: rtl/sprite_blitter_coord.sv
// blit_coord: maps a sprite pixel (row, col, sub-cell) to a vram cell and a clip flag.
// SPRITE_BLITTER_WRAP_EN: off-screen pixels wrap instead of being clipped.
module blit_coord
    import chip8_pkg::*;
#(
    parameter int VRAM_W = HIRES_W,
    parameter int VRAM_H = HIRES_H
) (
    input  logic       hires,
    input  logic [6:0] x,
    input  logic [5:0] y,
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic [1:0] sub,
    output logic [6:0] hpos,
    output logic [5:0] vpos,
    output logic       clip
);

    logic [7:0] w_lim;
    logic [6:0] h_lim;
    logic [6:0] x0;
    logic [5:0] y0;
    logic [7:0] px;
    logic [6:0] py;
    logic [6:0] pxw;
    logic [5:0] pyw;

    // Start position and overflow both stay below twice the limit, so one
    // conditional subtract is a full modulo.
    always_comb begin
        w_lim = hires ? 8'(VRAM_W) : 8'(VRAM_W / 2);
        h_lim = hires ? 7'(VRAM_H) : 7'(VRAM_H / 2);
        x0    = 7'(({1'b0, x} >= w_lim) ? ({1'b0, x} - w_lim) : {1'b0, x});
        y0    = 6'(({1'b0, y} >= h_lim) ? ({1'b0, y} - h_lim) : {1'b0, y});
        px    = {1'b0, x0} + {4'b0, col};
        py    = {1'b0, y0} + {3'b0, row};
        pxw   = 7'((px >= w_lim) ? (px - w_lim) : px);
        pyw   = 6'((py >= h_lim) ? (py - h_lim) : py);
`ifdef SPRITE_BLITTER_WRAP_EN
        clip  = 1'b0;
`else
        clip  = (px >= w_lim) || (py >= h_lim);
`endif
        hpos  = hires ? pxw : {pxw[5:0], sub[0]};
        vpos  = hires ? pyw : {pyw[4:0], sub[1]};
    end

endmodule

// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN sequencer: fetches sprite bytes and XORs them into 2-plane vram.
// SPRITE_BLITTER_WRAP_EN (in blit_coord) selects edge wrap instead of clipping.
module sprite_blitter
    import chip8_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int VRAM_W = 128,
    parameter int VRAM_H = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hires,
    input  logic [6:0]        x,
    input  logic [5:0]        y,
    input  logic [3:0]        n,
    input  logic [1:0]        plane_mask,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [6:0]        vram_hpos,
    output logic [5:0]        vram_vpos,
    input  logic [1:0]        vram_pixelo,
    output logic [1:0]        vram_pixeli,
    output logic              vram_we,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    state_t            state, nstate;
    logic              hires_q;
    logic [6:0]        x_q;
    logic [5:0]        y_q;
    logic [3:0]        n_q;
    logic              plane0_set;
    logic [1:0]        mask_left;
    logic [ADDR_W-1:0] base_q, addr_q, plane_off;
    logic [7:0]        shift;
    logic [2:0]        bitcnt;
    logic              byte_idx;
    logic [3:0]        row, rows_last;
    logic [1:0]        sub, sub_sel, pbit;
    logic              plane;
    logic [6:0]        hpos_q, c_hpos;
    logic [5:0]        vpos_q, c_vpos;
    logic              c_clip;
    logic              collision_q;
    logic              two_bytes, bit_last, byte_last, row_last;
    logic              draw_bit, more_cells, adv;

    assign two_bytes  = (n_q == 4'd0);
    assign rows_last  = two_bytes ? 4'(BIG_SPRITE_ROWS - 1) : n_q - 4'd1;
    assign plane_off  = two_bytes ? ADDR_W'(BIG_SPRITE_ROWS * 2) : ADDR_W'(n_q);
    assign bit_last   = &bitcnt;
    assign byte_last  = !two_bytes || byte_idx;
    assign row_last   = (row == rows_last);
    assign draw_bit   = shift[7] && !c_clip;
    assign more_cells = !hires_q && (sub != 2'd3);
    assign adv        = ((state == BIT) && !draw_bit) || ((state == WR) && !more_cells);
    assign sub_sel    = (state == WR) ? sub + 2'd1 : 2'd0;
    assign pbit       = plane ? 2'b10 : 2'b01;

    assign ram_addr   = addr_q;
    assign vram_hpos  = hpos_q;
    assign vram_vpos  = vpos_q;
    assign collision  = collision_q;

    blit_coord #(
        .VRAM_W(VRAM_W),
        .VRAM_H(VRAM_H)
    ) u_coord (
        .hires(hires_q),
        .x    (x_q),
        .y    (y_q),
        .row  (row),
        .col  ({byte_idx, bitcnt}),
        .sub  (sub_sel),
        .hpos (c_hpos),
        .vpos (c_vpos),
        .clip (c_clip)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate      = state;
        busy        = (state != IDLE) && (state != DONE);
        done        = (state == DONE);
        vram_we     = (state == WR);
        vram_pixeli = (state == WR) ? (vram_pixelo ^ pbit) : 2'b00;
        case (state)
            IDLE:    if (start) nstate = PLANE;
            PLANE:   nstate = (|mask_left) ? FETCH : DONE;
            FETCH:   nstate = LATCH;
            LATCH:   nstate = BIT;
            BIT:     if (draw_bit) nstate = RD;
            RD:      nstate = WR;
            WR:      if (more_cells) nstate = RD;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (adv) begin
            if (!bit_last)                   nstate = BIT;
            else if (!byte_last || !row_last) nstate = FETCH;
            else                             nstate = PLANE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hires_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            plane0_set  <= 1'b0;
            mask_left   <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            shift       <= '0;
            bitcnt      <= '0;
            byte_idx    <= 1'b0;
            row         <= '0;
            sub         <= '0;
            plane       <= 1'b0;
            hpos_q      <= '0;
            vpos_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    hires_q     <= hires;
                    x_q         <= x;
                    y_q         <= y;
                    n_q         <= n;
                    plane0_set  <= plane_mask[0];
                    mask_left   <= plane_mask;
                    base_q      <= i_addr;
                    collision_q <= 1'b0;
                end
                // Plane 1 data sits after plane 0 data only when plane 0 is drawn.
                PLANE: if (|mask_left) begin
                    plane     <= !mask_left[0];
                    mask_left <= {mask_left[1] & mask_left[0], 1'b0};
                    row       <= '0;
                    byte_idx  <= 1'b0;
                    addr_q    <= base_q + ((!mask_left[0] && plane0_set) ? plane_off : '0);
                end
                LATCH: begin
                    shift  <= ram_dout;
                    bitcnt <= '0;
                    addr_q <= addr_q + ADDR_W'(1);
                end
                BIT: if (draw_bit) begin
                    sub    <= '0;
                    hpos_q <= c_hpos;
                    vpos_q <= c_vpos;
                end
                WR: begin
                    if (|(vram_pixelo & pbit)) collision_q <= 1'b1;
                    if (more_cells) begin
                        sub    <= sub + 2'd1;
                        hpos_q <= c_hpos;
                        vpos_q <= c_vpos;
                    end
                end
                default: ;
            endcase
            if (adv) begin
                shift  <= {shift[6:0], 1'b0};
                bitcnt <= bitcnt + 3'd1;
                if (bit_last) begin
                    if (!byte_last) begin
                        byte_idx <= 1'b1;
                    end else begin
                        byte_idx <= 1'b0;
                        row      <= row + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter against a pixel-level reference model.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset, start, hires;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic [1:0]  plane_mask;
    logic [11:0] i_addr, ram_addr;
    logic [7:0]  ram_dout;
    logic [6:0]  vram_hpos;
    logic [5:0]  vram_vpos;
    logic [1:0]  vram_pixelo, vram_pixeli;
    logic        vram_we, busy, done, collision;

    always #5 clk = ~clk;

    sprite_blitter #(
        .ADDR_W(12),
        .VRAM_W(128),
        .VRAM_H(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .hires      (hires),
        .x          (x),
        .y          (y),
        .n          (n),
        .plane_mask (plane_mask),
        .i_addr     (i_addr),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .vram_hpos  (vram_hpos),
        .vram_vpos  (vram_vpos),
        .vram_pixelo(vram_pixelo),
        .vram_pixeli(vram_pixeli),
        .vram_we    (vram_we),
        .busy       (busy),
        .done       (done),
        .collision  (collision)
    );

    logic [7:0] ram   [0:4095];
    logic [1:0] vram  [0:63][0:127];
    logic [1:0] mvram [0:63][0:127];
    logic       load_req = 1'b0;

    int checks = 0;
    int fails  = 0;
    int exp_busy, exp_we;
    logic exp_col;
    int busy_last, we_last;

    // Synchronous memories; load_req copies the model screen into vram.
    always @(posedge clk) begin
        ram_dout    <= ram[ram_addr];
        vram_pixelo <= vram[vram_vpos][vram_hpos];
        if (load_req) begin
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 128; c++)
                    vram[r][c] <= mvram[r][c];
        end else if (vram_we) begin
            vram[vram_vpos][vram_hpos] <= vram_pixeli;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_vram();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    task automatic clear_model();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                mvram[r][c] = 2'b00;
    endtask

    task automatic compare_vram(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                if (vram[r][c] !== mvram[r][c]) bad++;
        check(tag, bad, 0);
    endtask

    // Walk the sprite pixel by pixel; also tallies the expected busy cycles:
    // one PLANE visit per plane plus the final one, 2 per byte fetch,
    // 1 per bit and 2 per cell read-modify-write.
    task automatic model_draw(input logic h, input logic [6:0] xx, input logic [5:0] yy,
                              input logic [3:0] nn, input logic [1:0] m, input logic [11:0] ia);
        int rows, bpr, w, hh, off, px, py, cx, cy, ncell;
        logic [7:0] b;
        rows = (nn == 0) ? 16 : int'(nn);
        bpr  = (nn == 0) ? 2 : 1;
        w    = h ? 128 : 64;
        hh   = h ? 64 : 32;
        exp_busy = 1; exp_we = 0; exp_col = 1'b0; off = 0;
        for (int p = 0; p < 2; p++) begin
            if (!m[p]) continue;
            exp_busy += 1;
            for (int r = 0; r < rows; r++) begin
                for (int k = 0; k < bpr; k++) begin
                    b = ram[(int'(ia) + off) % 4096];
                    off++;
                    exp_busy += 2;
                    for (int bi = 0; bi < 8; bi++) begin
                        exp_busy += 1;
                        if (!b[7-bi]) continue;
                        px = int'(xx) % w + k * 8 + bi;
                        py = int'(yy) % hh + r;
`ifdef SPRITE_BLITTER_WRAP_EN
                        px = px % w;
                        py = py % hh;
`else
                        if (px >= w || py >= hh) continue;
`endif
                        ncell = h ? 1 : 4;
                        for (int s = 0; s < ncell; s++) begin
                            cx = h ? px : 2 * px + s % 2;
                            cy = h ? py : 2 * py + s / 2;
                            if (mvram[cy][cx][p]) exp_col = 1'b1;
                            mvram[cy][cx][p] = ~mvram[cy][cx][p];
                            exp_busy += 2;
                            exp_we++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_draw(input string tag, input logic h, input logic [6:0] xx, input logic [5:0] yy,
                            input logic [3:0] nn, input logic [1:0] m, input logic [11:0] ia,
                            input int poke_at);
        int busy_cnt, we_cnt, done_at;
        logic [1:0] at_done;
        model_draw(h, xx, yy, nn, m, ia);
        @(negedge clk);
        hires = h; x = xx; y = yy; n = nn; plane_mask = m; i_addr = ia; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; we_cnt = 0; done_at = 0; at_done = 2'b00;
        for (int c = 1; c <= 20000; c++) begin
            if (vram_we) we_cnt++;
            if (done) begin
                done_at = c;
                at_done = {busy, done};
                break;
            end
            if (busy) busy_cnt++;
            start = (c == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "/done_at"}, done_at, exp_busy + 1);
        check({tag, "/busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "/writes"}, we_cnt, exp_we);
        check({tag, "/busy_done"}, at_done, 2'b01);
        check({tag, "/collision"}, collision, exp_col);
        busy_last = busy_cnt;
        we_last   = we_cnt;
        @(negedge clk);
        check({tag, "/after"}, {busy, done, vram_we}, 3'b000);
        compare_vram({tag, "/vram"});
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, ram_addr, vram_hpos, vram_vpos, vram_pixeli, vram_we, busy, done, collision};
    endfunction

    initial begin
        logic [7:0] wide;
        logic [6:0] rx;
        logic [5:0] ry;
        int seen;

        reset = 1'b1; start = 1'b0; hires = 1'b0; x = '0; y = '0; n = '0;
        plane_mask = '0; i_addr = '0;
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        clear_model();
        load_vram();
        repeat (2) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        reset = 1'b0;

        // Single hires pixel, then the same draw to erase it.
        ram[12'h200] = 8'h80;
        run_draw("t1", 1'b1, 7'd0, 6'd0, 4'd1, 2'b01, 12'h200, 0);
        check("t1_cycles", busy_last, 14);
        check("t1_cell", vram[0][0], 2'b01);
        run_draw("t2", 1'b1, 7'd0, 6'd0, 4'd1, 2'b01, 12'h200, 0);
        check("t2_cell", vram[0][0], 2'b00);
        check("t2_collision", collision, 1'b1);

        // Lores corner: second pixel falls off the right edge.
        ram[12'h210] = 8'hC0;
        run_draw("t3", 1'b0, 7'd63, 6'd31, 4'd1, 2'b01, 12'h210, 0);
        check("t3_cell", vram[62][126], 2'b01);
`ifdef SPRITE_BLITTER_WRAP_EN
        check("t3_writes", we_last, 8);
`else
        check("t3_writes", we_last, 4);
`endif

        // 16x16 on both planes over a random screen.
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                mvram[r][c] = 2'($urandom);
        load_vram();
        rx = 7'($urandom_range(0, 127));
        ry = 6'($urandom_range(0, 63));
        run_draw("t4", 1'b1, rx, ry, 4'd0, 2'b11, 12'h300, 0);

        // Start position wraps: 130 -> 2, 70 -> 6.
        clear_model();
        load_vram();
        ram[12'h220] = 8'h80;
        wide = 8'd130; rx = wide[6:0];
        wide = 8'd70;  ry = wide[5:0];
        run_draw("t5", 1'b1, rx, ry, 4'd1, 2'b01, 12'h220, 0);
        check("t5_cell", vram[6][2], 2'b01);

        // Empty plane mask.
        run_draw("t6", 1'b1, 7'd5, 6'd5, 4'd3, 2'b00, 12'h100, 0);
        check("t6_cycles", busy_last, 1);
        check("t6_writes", we_last, 0);

        // start while busy must neither restart nor queue.
        run_draw("t7", 1'b0, 7'($urandom), 6'($urandom), 4'd4, 2'b11, 12'h500, 3);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("t7_no_queue", seen, 0);
        compare_vram("t7/vram_after");

        // Reset mid-draw.
        for (int a = 12'h400; a < 12'h410; a++) ram[a] = 8'hFF;
        @(negedge clk);
        hires = 1'b0; x = 7'd3; y = 6'd3; n = 4'd8; plane_mask = 2'b11; i_addr = 12'h400;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t8_reset_outputs", out_vec(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("t8_no_done", seen, 0);
        clear_model();
        load_vram();
        run_draw("t8_redraw", 1'b0, 7'd3, 6'd3, 4'd8, 2'b11, 12'h400, 0);

        // ram address wrap at the top of memory.
        run_draw("t9", 1'b1, 7'd120, 6'd60, 4'd0, 2'b11, 12'hFF8, 0);

        for (int t = 0; t < 8; t++) begin
            run_draw("rnd", 1'($urandom), 7'($urandom), 6'($urandom),
                     4'($urandom), 2'($urandom), 12'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
